// File: rtl/cp_rca_seq_pkg.sv
// ============================================================================
// Module   : cp_rca_seq_pkg
// Brief    : Shared types and constants for the nibble-serial add/sub sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package cp_rca_seq_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Smallest width that can count 0..value-1 (minimum 1 bit).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cp_rca_4b.sv
// ============================================================================
// Module   : cp_rca_4b
// Brief    : 4-bit ripple-carry adder slice shared by the sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cp_rca_4b
    import cp_rca_seq_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_ci,
    output logic [NIB_W-1:0] o_s,
    output logic             o_co
);

    logic w_carry;

    always_comb begin
        w_carry = i_ci;
        o_s     = '0;
        for (int i = 0; i < NIB_W; i++) begin
            o_s[i]  = i_a[i] ^ i_b[i] ^ w_carry;
            w_carry = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
        end
        o_co = w_carry;
    end

endmodule

`default_nettype wire

// File: rtl/cp_rca_seq_ctrl.sv
// ============================================================================
// Module   : cp_rca_seq_ctrl
// Brief    : Multi-nibble add/subtract over one shared 4-bit ripple adder,
//            one nibble per clock, LSB first. Subtract gated by CP_RCA_SEQ_SUB_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cp_rca_seq_ctrl
    import cp_rca_seq_pkg::*;
#(
    parameter int NIBBLES = 4
)
(
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [NIB_W*NIBBLES-1:0] i_a,
    input  logic [NIB_W*NIBBLES-1:0] i_b,
    input  logic                     i_sub,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [NIB_W*NIBBLES-1:0] o_s,
    output logic                     o_cy,
    output logic                     o_ovf
);

    localparam int              C_W        = NIB_W * NIBBLES;
    localparam int              C_CNT_W    = clog2(NIBBLES);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(NIBBLES - 1);

    state_t             r_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [C_W-1:0]     r_a;
    logic [C_W-1:0]     r_b;
    logic [C_W-1:0]     r_sum;
    logic               r_carry;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_busy;
    logic               r_done;
    logic [C_W-1:0]     r_s;
    logic               r_cy_out;
    logic               r_ovf;

    logic               w_sub_eff;
    logic [C_W-1:0]     w_b_eff;
    logic [NIB_W-1:0]   w_a_nib;
    logic [NIB_W-1:0]   w_b_nib;
    logic [NIB_W-1:0]   w_nib_s;
    logic               w_nib_co;
    logic [C_W-1:0]     w_sum_next;

`ifdef CP_RCA_SEQ_SUB_EN
    assign w_sub_eff = i_sub;
    assign w_b_eff   = i_sub ? ~i_b : i_b;
`else
    logic w_unused_sub;
    assign w_unused_sub = i_sub;
    assign w_sub_eff    = 1'b0;
    assign w_b_eff      = i_b;
`endif

    assign w_a_nib = r_a[NIB_W*int'(r_cnt) +: NIB_W];
    assign w_b_nib = r_b[NIB_W*int'(r_cnt) +: NIB_W];

    cp_rca_4b u_rca (
        .i_a  (w_a_nib),
        .i_b  (w_b_nib),
        .i_ci (r_carry),
        .o_s  (w_nib_s),
        .o_co (w_nib_co)
    );

    // Working sum with the current nibble merged in, so the final edge can
    // publish the complete result without an extra cycle.
    always_comb begin
        w_sum_next = r_sum;
        w_sum_next[NIB_W*int'(r_cnt) +: NIB_W] = w_nib_s;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sum    <= '0;
            r_carry  <= 1'b0;
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_s      <= '0;
            r_cy_out <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_a     <= i_a;
                        r_b     <= w_b_eff;
                        r_carry <= w_sub_eff;
                        r_a_msb <= i_a[C_W-1];
                        r_b_msb <= w_b_eff[C_W-1];
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_nib_co;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == C_CNT_LAST) begin
                        r_state  <= ST_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_s      <= w_sum_next;
                        r_cy_out <= w_nib_co;
                        r_ovf    <= (r_a_msb == r_b_msb) && (w_nib_s[NIB_W-1] != r_a_msb);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_s    = r_s;
    assign o_cy   = r_cy_out;
    assign o_ovf  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_cp_rca_seq_ctrl.sv
// ============================================================================
// Module   : tb_cp_rca_seq_ctrl
// Brief    : Directed vector bench for cp_rca_seq_ctrl (NIBBLES=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cp_rca_seq_ctrl;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cy;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] s;
        logic         cy;
        logic         ovf;
    } vec_t;

    vec_t vecs [7];

    cp_rca_seq_ctrl #(.NIBBLES(N)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_sub   (sub),
        .o_busy  (busy),
        .o_done  (done),
        .o_s     (s),
        .o_cy    (cy),
        .o_ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int idx);
        @(negedge clk);
        a = v.a; b = v.b; sub = v.sub; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d busy_after_accept", idx), 32'(busy), 32'd1);
        for (int k = 1; k <= N; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == N - 1) chk($sformatf("v%0d done_early", idx), 32'(done), 32'd0);
        end
        chk($sformatf("v%0d done", idx), 32'(done), 32'd1);
        chk($sformatf("v%0d busy_in_done", idx), 32'(busy), 32'd0);
        chk($sformatf("v%0d s", idx), 32'(s), 32'(v.s));
        chk($sformatf("v%0d cy", idx), 32'(cy), 32'(v.cy));
        chk($sformatf("v%0d ovf", idx), 32'(ovf), 32'(v.ovf));
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d done_pulse_end", idx), 32'(done), 32'd0);
        chk($sformatf("v%0d s_held", idx), 32'(s), 32'(v.s));
    endtask

    initial begin
        int n_done;

        vecs[0] = '{a: 16'h1234, b: 16'h0FFF, sub: 1'b0, s: 16'h2233, cy: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0001, sub: 1'b0, s: 16'h0000, cy: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 16'h7FFF, b: 16'h0001, sub: 1'b0, s: 16'h8000, cy: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 16'h8000, b: 16'h8000, sub: 1'b0, s: 16'h0000, cy: 1'b1, ovf: 1'b1};
        vecs[4] = '{a: 16'h0F0F, b: 16'h00F1, sub: 1'b0, s: 16'h1000, cy: 1'b0, ovf: 1'b0};
`ifdef CP_RCA_SEQ_SUB_EN
        vecs[5] = '{a: 16'h0005, b: 16'h0007, sub: 1'b1, s: 16'hFFFE, cy: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 16'h8000, b: 16'h0001, sub: 1'b1, s: 16'h7FFF, cy: 1'b1, ovf: 1'b1};
`else
        vecs[5] = '{a: 16'h0005, b: 16'h0007, sub: 1'b1, s: 16'h000C, cy: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 16'h8000, b: 16'h0001, sub: 1'b1, s: 16'h8001, cy: 1'b0, ovf: 1'b0};
`endif

        rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset s", 32'(s), 32'd0);
        chk("reset cy_ovf", {30'd0, cy, ovf}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i], i);
        end

        // Start during RUN is ignored; start in the done cycle chains a new op.
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 a = 16'hFFFF; b = 16'h0001; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("ign busy", 32'(busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("ign done", 32'(done), 32'd1);
        chk("ign s", 32'(s), 32'h2233);
        chk("ign cy", 32'(cy), 32'd0);
        a = 16'h0001; b = 16'h0002; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b busy", 32'(busy), 32'd1);
        chk("b2b s_held", 32'(s), 32'h2233);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("b2b done_early", 32'(done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("b2b done", 32'(done), 32'd1);
        chk("b2b s", 32'(s), 32'h0003);
        @(posedge clk);

        // Reset while nibble 2 is in flight aborts without a done pulse.
        @(negedge clk);
        a = 16'hAAAA; b = 16'h1111; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort s", 32'(s), 32'd0);
        chk("abort cy_ovf", {30'd0, cy, ovf}, 32'd0);
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort no_done", 32'(n_done), 32'd0);

        // Reset beats a simultaneous start.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0001; sub = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("rst_vs_start busy", 32'(busy), 32'd0);

        run_op('{a: 16'h0001, b: 16'h0001, sub: 1'b0, s: 16'h0002, cy: 1'b0, ovf: 1'b0}, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cp_rca_seq_ctrl.md
# cp_rca_seq_ctrl

Sequencer that performs multi-nibble add/subtract on wide operands using a single shared 4-bit ripple-carry adder (`cp_rca_4b`). It processes one nibble per clock, LSB first, and holds the carry in a register between nibbles. This lets the team build 8/16/32-bit adders without replicating carry chains. It sits between a requesting datapath (start/done handshake) and the adder instance it owns.

## Interface
- `NIBBLES`, default 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..16.
- `i_clk`  input  1  clock; all state updates on the rising edge.
- `i_rst`  input  1  synchronous, active-high reset.
- `i_start`  input  1  request; accepted only when the block is ready (`o_busy`=0).
- `i_a`  input  W  operand A; sampled on the accepting edge only.
- `i_b`  input  W  operand B; sampled on the accepting edge only.
- `i_sub`  input  1  1 = A−B, 0 = A+B; sampled on the accepting edge.
- `o_busy`  output  1  high while nibbles are in flight.
- `o_done`  output  1  one-cycle pulse; the result is valid from this cycle on.
- `o_s`  output  W  result; held stable until the next completion.
- `o_cy`  output  1  final carry-out (for subtract: 1 = no borrow).
- `o_ovf`  output  1  signed two's-complement overflow of the W-bit result.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `i_start`.
  - RUN→DONE when the nibble counter reaches NIBBLES−1.
  - DONE→RUN if `i_start`, else DONE→IDLE.
- On accept:
  - Latch A into the working register.
  - Latch B into the working register, bitwise inverted if subtracting.
  - Load the carry register with `i_sub`.
  - Clear the nibble counter and latch the MSBs of A and effective-B for overflow.
- Each RUN cycle:
  - Present slice [4k+3:4k] of A and effective-B, plus the carry register, to the adder.
  - Register the sum slice into the working sum and the adder carry into the carry register.
  - Increment k.
- Last RUN cycle: copy the full working sum to `o_s`, the final carry to `o_cy`, and ovf to `o_ovf`.
  - ovf = (a_msb == beff_msb) & (sum_msb != a_msb).
- `o_s`, `o_cy` and `o_ovf` change only on that update edge.
- `i_start` while `o_busy`=1 is ignored: no queueing, no error flag.
- Arithmetic is modulo 2^W. Carry-out does not wrap into the result.
- Reset:
  - Forces IDLE, counter 0, carry register 0.
  - All outputs go to 0 (`o_busy`, `o_done`, `o_s`, `o_cy`, `o_ovf`).
  - Reset mid-RUN aborts the operation with no `o_done`.
  - Reset wins over a simultaneous `i_start`.

## Timing
- Accepting edge E0. Nibble k is registered at edge E(k+1).
- `o_busy` = 1 from after E0 through the cycle ending at E(NIBBLES); low while in DONE.
- `o_done` = 1 for exactly the one cycle after E(NIBBLES). The result is valid in that same cycle.
- Latency from `i_start` to `o_done` is NIBBLES+1 cycles. Throughput is one operation per NIBBLES+1 cycles.
- Back-to-back: `i_start` during the `o_done` cycle is accepted. The next `o_done` follows NIBBLES+1 cycles later.
- The critical path is one 4-bit ripple plus mux/register. There is no combinational path from input to output.

## Configuration
- Macro: `CP_RCA_SEQ_SUB_EN`.
  - Defined: subtract support as described above.
  - Undefined: `i_sub` is ignored (port retained), B is never inverted, and the initial carry is 0. The inverter mux is removed.

## Structure
- Shared package `cp_rca_seq_pkg` holds:
  - the FSM state enum typedef (IDLE/RUN/DONE);
  - the constant NIB_W = 4;
  - the counter width function clog2(NIBBLES).
- One sub-module: a single instance of `cp_rca_4b`, driven from slice muxes. No other hierarchy.

## Test plan
All scenarios use NIBBLES=4.
- Add 0x1234 + 0x0FFF, i_sub=0 → `o_s`=0x2233, `o_cy`=0, `o_ovf`=0. `o_done` is a 1-cycle pulse 5 cycles after start.
- Add 0xFFFF + 0x0001 → `o_s`=0x0000, `o_cy`=1, `o_ovf`=0. This exercises carry through all nibbles.
- Add 0x7FFF + 0x0001 → `o_s`=0x8000, `o_cy`=0, `o_ovf`=1.
- With `CP_RCA_SEQ_SUB_EN`: 0x0005 − 0x0007 → `o_s`=0xFFFE, `o_cy`=0, `o_ovf`=0. Without the macro, the same stimulus gives `o_s`=0x000C.
- Pulse `i_start` with new operands at cycle 2 of RUN → ignored; the first result is unchanged. `i_start` in the `o_done` cycle → second operation completes 5 cycles later.
- Assert `i_rst` during RUN, nibble 2 → next cycle all outputs are 0 and no `o_done` appears. A subsequent start of 0x0001+0x0001 → `o_s`=0x0002.
